// File: rtl/ring_boundary_buffer_pkg.sv
// Shared defaults and helpers for the ring link boundary buffer.
package ring_boundary_buffer_pkg;

    // Link flit width and default boundary geometry.
    localparam int unsigned ControlW         = 144;
    localparam int unsigned BoundaryDepth    = 4;
    localparam int unsigned BoundaryChannels = 2;

    // Occupancy after one edge given the push/pop handshakes of that edge.
    function automatic int unsigned occ_next(int unsigned occ, logic push, logic pop);
        case ({push, pop})
            2'b10:   return occ + 1;
            2'b01:   return occ - 1;
            default: return occ;
        endcase
    endfunction

endpackage

// File: rtl/boundary_fifo.sv
// One channel of the boundary buffer: storage, pointers, occupancy and sticky overflow.
module boundary_fifo
    import ring_boundary_buffer_pkg::*;
#(
    parameter int unsigned FLIT_W = ControlW,
    parameter int unsigned DEPTH  = BoundaryDepth,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [FLIT_W-1:0] in_flit_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [FLIT_W-1:0] out_flit_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  occupancy_o,
    output logic              overflow_o
);

    localparam int unsigned      PtrW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] Full = CNT_W'(DEPTH);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;

    // Handshakes, flags and next-state; ready depends on registered count only.
    always_comb begin
        in_ready_o  = (count_q != Full);
        out_valid_o = (count_q != '0);
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i;
        // Pointers are log2(DEPTH) wide so they wrap on their own.
        wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d     = CNT_W'(occ_next(32'(count_q), push, pop));
        overflow_d  = overflow_q | (in_valid_i & ~in_ready_o);
        out_flit_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
        occupancy_o = count_q;
        overflow_o  = overflow_q;
    end

    // Control state; reset empties the FIFO and clears the sticky flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; stale entries are masked by the empty check.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_flit_i;
        end
    end

endmodule

// File: rtl/ring_boundary_buffer.sv
// Multi-channel elastic boundary stage for hring links: one FIFO per channel.
module ring_boundary_buffer
    import ring_boundary_buffer_pkg::*;
#(
    parameter int unsigned FLIT_W   = ControlW,
    parameter int unsigned CHANNELS = BoundaryChannels,
    parameter int unsigned DEPTH    = BoundaryDepth,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS*FLIT_W-1:0] in_flit,
    input  logic [CHANNELS-1:0]        in_valid,
    output logic [CHANNELS-1:0]        in_ready,
    output logic [CHANNELS*FLIT_W-1:0] out_flit,
    output logic [CHANNELS-1:0]        out_valid,
    input  logic [CHANNELS-1:0]        out_ready,
    output logic [CHANNELS*CNT_W-1:0]  occupancy,
    output logic [CHANNELS-1:0]        overflow
);

    // Channels are independent; just slice the packed vectors per instance.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        boundary_fifo #(
            .FLIT_W(FLIT_W),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk_i      (clk),
            .rst_ni     (rst),
            .in_flit_i  (in_flit[c*FLIT_W +: FLIT_W]),
            .in_valid_i (in_valid[c]),
            .in_ready_o (in_ready[c]),
            .out_flit_o (out_flit[c*FLIT_W +: FLIT_W]),
            .out_valid_o(out_valid[c]),
            .out_ready_i(out_ready[c]),
            .occupancy_o(occupancy[c*CNT_W +: CNT_W]),
            .overflow_o (overflow[c])
        );
    end

endmodule

// File: tb/tb_ring_boundary_buffer.sv
// Self-checking bench: directed plan steps plus random traffic against a queue model.
module tb_ring_boundary_buffer;

    localparam int FLIT_W = 144;
    localparam int CH     = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [CH*FLIT_W-1:0] in_flit;
    logic [CH-1:0]        in_valid;
    logic [CH-1:0]        in_ready;
    logic [CH*FLIT_W-1:0] out_flit;
    logic [CH-1:0]        out_valid;
    logic [CH-1:0]        out_ready;
    logic [CH*CNT_W-1:0]  occupancy;
    logic [CH-1:0]        overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue and one sticky flag per channel.
    logic [FLIT_W-1:0] mq [CH][$];
    logic              movf [CH];

    always #5 clk = ~clk;

    ring_boundary_buffer #(
        .FLIT_W  (FLIT_W),
        .CHANNELS(CH),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_flit  (in_flit),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_flit (out_flit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [FLIT_W-1:0] got,
                       input logic [FLIT_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            mq[c].delete();
            movf[c] = 1'b0;
        end
    endtask

    // Advance one edge, applying the handshake rules to the model using pre-edge state.
    task automatic tick();
        @(posedge clk);
        for (int c = 0; c < CH; c++) begin
            int sz;
            logic do_push, do_pop;
            sz      = mq[c].size();
            do_push = in_valid[c] && (sz < DEPTH);
            do_pop  = out_ready[c] && (sz > 0);
            if (in_valid[c] && sz == DEPTH) movf[c] = 1'b1;
            if (do_pop) void'(mq[c].pop_front());
            if (do_push) mq[c].push_back(in_flit[c*FLIT_W +: FLIT_W]);
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < CH; c++) begin
            int sz;
            logic [FLIT_W-1:0] ef;
            sz = mq[c].size();
            ef = (sz > 0) ? mq[c][0] : '0;
            chk($sformatf("%s.ch%0d.out_valid", tag, c), FLIT_W'(out_valid[c]), FLIT_W'(sz != 0));
            chk($sformatf("%s.ch%0d.in_ready", tag, c), FLIT_W'(in_ready[c]),
                FLIT_W'(sz != DEPTH));
            chk($sformatf("%s.ch%0d.occupancy", tag, c),
                FLIT_W'(occupancy[c*CNT_W +: CNT_W]), FLIT_W'(sz));
            chk($sformatf("%s.ch%0d.out_flit", tag, c), out_flit[c*FLIT_W +: FLIT_W], ef);
            chk($sformatf("%s.ch%0d.overflow", tag, c), FLIT_W'(overflow[c]), FLIT_W'(movf[c]));
        end
    endtask

    task automatic set_flit(input int c, input logic [FLIT_W-1:0] f);
        in_flit[c*FLIT_W +: FLIT_W] = f;
    endtask

    function automatic logic [FLIT_W-1:0] rand_flit();
        return FLIT_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    initial begin
        // Reset state.
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_flit   = '0;
        model_reset();
        #2 rst = 1'b0;
        #1 check_all("in_reset");
        #9 rst = 1'b1;
        tick();
        check_all("after_reset");

        // Single push on ch0; ch1 untouched.
        set_flit(0, 144'h0123456789abcdef0123456789abcdef);
        in_valid = 2'b01;
        tick();
        in_valid = '0;
        check_all("single_push");
        chk("single_push.flit_const", out_flit[0 +: FLIT_W], 144'h0123456789abcdef0123456789abcdef);
        chk("single_push.ch1_idle", FLIT_W'(out_valid[1]), '0);
        out_ready = 2'b01;
        tick();
        out_ready = '0;
        check_all("single_pop");

        // Fill ch0 with 1..4, then offer 5 while full.
        for (int i = 1; i <= 4; i++) begin
            set_flit(0, FLIT_W'(i));
            in_valid = 2'b01;
            tick();
            check_all($sformatf("fill%0d", i));
        end
        set_flit(0, FLIT_W'(5));
        tick();
        in_valid = '0;
        check_all("offer5");
        chk("offer5.in_ready", FLIT_W'(in_ready[0]), '0);
        chk("offer5.overflow", FLIT_W'(overflow[0]), FLIT_W'(1));
        chk("offer5.occupancy", FLIT_W'(occupancy[0 +: CNT_W]), FLIT_W'(DEPTH));

        // Drain: 1,2,3,4 then empty.
        out_ready = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain%0d.flit", i), out_flit[0 +: FLIT_W], FLIT_W'(i));
            tick();
            check_all($sformatf("drain%0d", i));
        end
        out_ready = '0;
        chk("drain.empty", FLIT_W'(out_valid[0]), '0);

        // Full with simultaneous push and pop: push refused, pop taken.
        for (int i = 11; i <= 14; i++) begin
            set_flit(0, FLIT_W'(i));
            in_valid = 2'b01;
            tick();
        end
        set_flit(0, FLIT_W'(15));
        out_ready = 2'b01;
        chk("fullpp.pre_in_ready", FLIT_W'(in_ready[0]), '0);
        tick();
        in_valid  = '0;
        out_ready = '0;
        check_all("fullpp");
        chk("fullpp.occupancy", FLIT_W'(occupancy[0 +: CNT_W]), FLIT_W'(3));
        chk("fullpp.in_ready", FLIT_W'(in_ready[0]), FLIT_W'(1));
        chk("fullpp.head", out_flit[0 +: FLIT_W], FLIT_W'(12));
        out_ready = 2'b01;
        repeat (3) tick();
        out_ready = '0;
        check_all("fullpp_drain");

        // Streaming on both channels, one flit per cycle.
        in_valid  = 2'b11;
        out_ready = 2'b11;
        for (int i = 0; i < 10; i++) begin
            set_flit(0, FLIT_W'(i));
            set_flit(1, FLIT_W'(100 + i));
            tick();
            check_all($sformatf("stream%0d", i));
            chk($sformatf("stream%0d.occ0", i), FLIT_W'(occupancy[0 +: CNT_W]), FLIT_W'(1));
            chk($sformatf("stream%0d.flit1", i), out_flit[FLIT_W +: FLIT_W], FLIT_W'(100 + i));
        end
        in_valid = '0;
        tick();
        check_all("stream_end");

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            in_valid  = CH'($urandom);
            out_ready = CH'($urandom);
            for (int c = 0; c < CH; c++) set_flit(c, rand_flit());
            tick();
            check_all("rand");
        end
        in_valid  = '0;
        out_ready = 2'b11;
        repeat (DEPTH + 1) tick();
        check_all("rand_drain");

        // Asynchronous reset between edges with three flits queued on ch1.
        out_ready = '0;
        in_valid  = 2'b10;
        for (int i = 0; i < 3; i++) begin
            set_flit(1, FLIT_W'(200 + i));
            tick();
        end
        in_valid = '0;
        chk("pre_rst.occ1", FLIT_W'(occupancy[CNT_W +: CNT_W]), FLIT_W'(3));
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #3 rst = 1'b1;
        tick();
        check_all("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
